io_out_fifo: RTL and testbench
==============================

IO_OUT_FIFO -- requirements
Module: io_out_fifo

Interface
REQ-001 Parameter WIDTH, default 16, width of the processor output word.
REQ-002 Parameter DEPTH, default 4, FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock, all state on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low: asserted when 0, sampled on the clk rising edge.
REQ-005 io_out  input  WIDTH  processor ioOut bus, sampled every cycle.
REQ-006 host_data  output  WIDTH  head-of-FIFO word.
REQ-007 host_valid  output  1  head entry present.
REQ-008 host_ready  input  1  host accepts head this cycle.
REQ-009 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 overflow  output  1  sticky: a capture was dropped.
REQ-011 clr_ovf  input  1  clears overflow.

Function
REQ-012 Capture register last_q holds the previous io_out sample and is updated every cycle.
REQ-013 Change detect: push = (io_out != last_q), registered once, so io_out sampled at edge N enters the FIFO at edge N+1.
REQ-014 Pop = host_valid && host_ready; the entry leaves at that edge, and the next entry appears on host_data the same cycle the pointer moves.
REQ-015 host_data/host_valid driven from FIFO state registers only, with no combinational path from io_out.
REQ-016 Not full, push: write at wr_ptr, wr_ptr+1 modulo DEPTH, count+1.
REQ-017 Full, push, no pop: word dropped, FIFO unchanged, overflow set.
REQ-018 Full, push and pop in the same cycle: both occur, count stays DEPTH, overflow not set.
REQ-019 Empty, pop requested: ignored, because host_valid=0.
REQ-020 Empty, push: word visible on host_data the cycle after the write, with no bypass.
REQ-021 Pointers are $clog2(DEPTH)+1 bits; the MSB difference distinguishes full from empty; wrap is natural modulo.
REQ-022 clr_ovf in the same cycle as a new overflow event: set wins.
REQ-023 host_data while host_valid=0 is don't-care; the bench does not check it.

Reset
REQ-024 reset=0 at an edge: wr_ptr=0, rd_ptr=0, count=0, host_valid=0, overflow=0, pending push=0, last_q=0.
REQ-025 Reset mid-operation discards all entries, including a push pending in the detect stage.
REQ-026 FIFO storage is not reset; the content is don't-care until written.
REQ-027 After reset deassertion, io_out != 0 in the first sampled cycle is captured (last_q=0).

Configuration
REQ-028 Macro IO_OUT_TIMESTAMP_EN defined: a 16-bit free-running cycle counter is added.
- Reset to 0, wraps at 65535.
- Stored with each entry and presented on added output host_ts[15:0], aligned with host_data.
- The stamp is the counter value on the cycle io_out was sampled.
REQ-029 Macro undefined: no counter, no host_ts port, and the FIFO storage width is WIDTH.

Structure
REQ-030 Shared package io_pkg holds:
- IO_WIDTH=16
- IO_TS_WIDTH=16
- the entry typedef io_entry_t (data, plus ts under the macro).
REQ-031 Single sub-module io_fifo_mem: DEPTH x entry register array, one write port, one asynchronous read port, no reset.
REQ-032 Control (pointers, count, overflow, change detect) resides in io_out_fifo.

Verification
REQ-033 Reset, then io_out 0 -> 11 at cycle 5, host_ready=1 -> host_valid high at cycle 7 with host_data=11, then low after the pop.
REQ-034 host_ready=0, io_out steps 1,2,3,4,5 on consecutive cycles, DEPTH=4 -> count=4, overflow=1, and pops yield 1,2,3,4 in order.
REQ-035 Full FIFO, io_out change with host_ready=1 in the same cycle -> count stays 4, overflow stays 0, new word appears last.
REQ-036 Three entries queued, reset=0 for one cycle -> count=0, host_valid=0 next cycle, overflow=0.
REQ-037 io_out held constant at 5040 for 100 cycles after a single capture -> exactly one entry, count=1.
REQ-038 With IO_OUT_TIMESTAMP_EN: io_out changes at cycles 10 and 20 after reset -> host_ts values 10 and 20, paired with the correct data.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the processor output-port FIFO.
// Optional feature macro: IO_OUT_TIMESTAMP_EN adds a 16-bit capture timestamp
// to every FIFO entry.
package io_pkg;

    localparam int IO_WIDTH    = 16;
    localparam int IO_TS_WIDTH = 16;

`ifdef IO_OUT_TIMESTAMP_EN
    // Entry layout at the default data width: timestamp above data.
    typedef struct packed {
        logic [IO_TS_WIDTH-1:0] ts;
        logic [IO_WIDTH-1:0]    data;
    } io_entry_t;
`else
    // Entry layout at the default data width: data only.
    typedef struct packed {
        logic [IO_WIDTH-1:0] data;
    } io_entry_t;
`endif

    // Stored entry width for a given data width (data plus optional stamp).
    function automatic int entry_width(input int data_width);
`ifdef IO_OUT_TIMESTAMP_EN
        return data_width + IO_TS_WIDTH;
`else
        return data_width;
`endif
    endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// Register-array storage for io_out_fifo: one write port, one asynchronous
// read port. Contents are not reset; the control logic never presents an
// entry that has not been written.
module io_fifo_mem #(
    parameter int EW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem_r [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Captures changes on the processor ioOut bus into a small FIFO for the host.
// A new word is queued whenever io_out differs from the previous sample; the
// detect stage is registered, so a word sampled at one edge is written at the
// next. Optional feature macro: IO_OUT_TIMESTAMP_EN (host_ts output carrying
// the free-running cycle count at which each word was sampled).
module io_out_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           io_out,
    output logic [WIDTH-1:0]           host_data,
    output logic                       host_valid,
    input  logic                       host_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef IO_OUT_TIMESTAMP_EN
    ,
    output logic [IO_TS_WIDTH-1:0]     host_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = entry_width(WIDTH);

    // Detect stage and FIFO control state.
    logic [WIDTH-1:0] last_q_r;
    logic             pend_r;
    logic [WIDTH-1:0] pend_data_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    count_r;
    logic             valid_r;
    logic             ovf_r;

    // Next-state and datapath signals.
    logic             full_s;
    logic             pop_s;
    logic             wr_en_s;
    logic             drop_s;
    logic             ovf_nxt_s;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [EW-1:0]    wr_entry_s;
    logic [EW-1:0]    rd_entry_s;

`ifdef IO_OUT_TIMESTAMP_EN
    logic [IO_TS_WIDTH-1:0] ts_cnt_r;
    logic [IO_TS_WIDTH-1:0] pend_ts_r;

    // Free-running cycle counter; wraps naturally at 65535.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_cnt_r <= {IO_TS_WIDTH{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + IO_TS_WIDTH'(1);
        end
    end

    // Hold the stamp of the sampling cycle alongside the pending word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_ts_r <= {IO_TS_WIDTH{1'b0}};
        end else begin
            pend_ts_r <= ts_cnt_r;
        end
    end

    assign wr_entry_s = {pend_ts_r, pend_data_r};
    assign host_ts    = rd_entry_s[EW-1:WIDTH];
`else
    assign wr_entry_s = pend_data_r;
`endif

    // Full when the pointers address the same slot but differ in the wrap bit.
    assign full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // Decide push/pop/drop for this cycle and the resulting next state.
    always_comb begin
        pop_s        = valid_r && host_ready;
        wr_en_s      = 1'b0;
        drop_s       = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        ovf_nxt_s    = ovf_r;

        if (pend_r) begin
            if (!full_s || pop_s) begin
                wr_en_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Sample io_out every cycle and register the change-detect result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q_r    <= {WIDTH{1'b0}};
            pend_r      <= 1'b0;
            pend_data_r <= {WIDTH{1'b0}};
        end else begin
            last_q_r    <= io_out;
            pend_r      <= (io_out != last_q_r);
            pend_data_r <= io_out;
        end
    end

    // Pointer, occupancy, valid and overflow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {PW{1'b0}};
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            ovf_r    <= ovf_nxt_s;
        end
    end

    io_fifo_mem #(
        .EW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rd_entry_s)
    );

    assign host_data  = rd_entry_s[WIDTH-1:0];
    assign host_valid = valid_r;
    assign count      = count_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed, table-driven bench for io_out_fifo (WIDTH=16, DEPTH=4).
// Inputs are changed #1 after a rising edge; outputs are checked #1 after
// the following rising edge.
module tb_io_out_fifo;

    logic        clk;
    logic        reset;
    logic [15:0] io_out;
    logic [15:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf;
`ifdef IO_OUT_TIMESTAMP_EN
    logic [15:0] host_ts;
`endif

    int n_chk = 0;
    int n_err = 0;

    io_out_fifo #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_out     (io_out),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
`ifdef IO_OUT_TIMESTAMP_EN
        ,
        .host_ts    (host_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] io;
        logic        rdy;
        logic        clr;
        logic        exp_v;
        logic [15:0] exp_d;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int rst, input int io, input int rdy, input int clr,
                                input int v, input int d, input int cnt, input int ovf);
        vec_t r;
        r.rst     = rst[0];
        r.io      = io[15:0];
        r.rdy     = rdy[0];
        r.clr     = clr[0];
        r.exp_v   = v[0];
        r.exp_d   = d[15:0];
        r.exp_cnt = cnt[2:0];
        r.exp_ovf = ovf[0];
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        io_out     = 16'd0;
        host_ready = 1'b0;
        clr_ovf    = 1'b0;

        //            rst io  rdy clr   v  d  cnt ovf
        vecs[0]  = mk(0,  0,  0,  0,    0, 0, 0, 0);   // reset state
        vecs[1]  = mk(0,  0,  0,  0,    0, 0, 0, 0);
        vecs[2]  = mk(1,  0,  1,  0,    0, 0, 0, 0);
        vecs[3]  = mk(1, 11,  1,  0,    0, 0, 0, 0);   // change sampled
        vecs[4]  = mk(1, 11,  1,  0,    1, 11, 1, 0);  // written, visible
        vecs[5]  = mk(1, 11,  1,  0,    0, 0, 0, 0);   // popped
        vecs[6]  = mk(1,  1,  0,  0,    0, 0, 0, 0);   // fill 1..5, host stalled
        vecs[7]  = mk(1,  2,  0,  0,    1, 1, 1, 0);
        vecs[8]  = mk(1,  3,  0,  0,    1, 1, 2, 0);
        vecs[9]  = mk(1,  4,  0,  0,    1, 1, 3, 0);
        vecs[10] = mk(1,  5,  0,  0,    1, 1, 4, 0);
        vecs[11] = mk(1,  5,  0,  0,    1, 1, 4, 1);   // 5 dropped
        vecs[12] = mk(1,  5,  0,  0,    1, 1, 4, 1);   // sticky
        vecs[13] = mk(1,  5,  0,  1,    1, 1, 4, 0);   // clear
        vecs[14] = mk(1,  6,  0,  0,    1, 1, 4, 0);   // 6 pending while full
        vecs[15] = mk(1,  6,  1,  0,    1, 2, 4, 0);   // push+pop while full
        vecs[16] = mk(1,  6,  1,  0,    1, 3, 3, 0);
        vecs[17] = mk(1,  6,  1,  0,    1, 4, 2, 0);
        vecs[18] = mk(1,  6,  1,  0,    1, 6, 1, 0);   // new word last
        vecs[19] = mk(1,  6,  1,  0,    0, 0, 0, 0);
        vecs[20] = mk(1,  7,  0,  0,    0, 0, 0, 0);   // queue three, then reset
        vecs[21] = mk(1,  8,  0,  0,    1, 7, 1, 0);
        vecs[22] = mk(1,  9,  0,  0,    1, 7, 2, 0);
        vecs[23] = mk(1,  9,  0,  0,    1, 7, 3, 0);
        vecs[24] = mk(1, 10,  0,  0,    1, 7, 3, 0);   // 10 pending in detect
        vecs[25] = mk(0, 10,  0,  0,    0, 0, 0, 0);   // reset discards all
        vecs[26] = mk(1, 10,  0,  0,    0, 0, 0, 0);   // nonzero first sample captured
        vecs[27] = mk(1, 10,  0,  0,    1, 10, 1, 0);
        vecs[28] = mk(1, 10,  1,  0,    0, 0, 0, 0);
        vecs[29] = mk(1,  1,  0,  0,    0, 0, 0, 0);   // refill for set-wins case
        vecs[30] = mk(1,  2,  0,  0,    1, 1, 1, 0);
        vecs[31] = mk(1,  3,  0,  0,    1, 1, 2, 0);
        vecs[32] = mk(1,  4,  0,  0,    1, 1, 3, 0);
        vecs[33] = mk(1,  5,  0,  0,    1, 1, 4, 0);
        vecs[34] = mk(1,  5,  0,  1,    1, 1, 4, 1);   // drop with clear: set wins
        vecs[35] = mk(1,  5,  0,  0,    1, 1, 4, 1);
        vecs[36] = mk(0,  5,  0,  0,    0, 0, 0, 0);   // reset clears overflow

        #1;
        for (int i = 0; i < NVEC; i++) begin
            reset      = vecs[i].rst;
            io_out     = vecs[i].io;
            host_ready = vecs[i].rdy;
            clr_ovf    = vecs[i].clr;
            step();
            chk("host_valid", i, 32'(host_valid), 32'(vecs[i].exp_v));
            chk("count",      i, 32'(count),      32'(vecs[i].exp_cnt));
            chk("overflow",   i, 32'(overflow),   32'(vecs[i].exp_ovf));
            if (vecs[i].exp_v) begin
                chk("host_data", i, 32'(host_data), 32'(vecs[i].exp_d));
            end
        end

        // A value held for 100 cycles after its capture yields one entry.
        reset      = 1'b1;
        clr_ovf    = 1'b0;
        host_ready = 1'b0;
        io_out     = 16'd5040;
        for (int i = 0; i < 101; i++) begin
            step();
        end
        chk("hold_count", 100, 32'(count),      32'd1);
        chk("hold_valid", 100, 32'(host_valid), 32'd1);
        chk("hold_data",  100, 32'(host_data),  32'd5040);
        chk("hold_ovf",   100, 32'(overflow),   32'd0);

`ifdef IO_OUT_TIMESTAMP_EN
        // Changes at cycles 10 and 20 after reset carry stamps 10 and 20.
        io_out     = 16'd0;
        reset      = 1'b0;
        host_ready = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        io_out = 16'h00AA;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        io_out = 16'h00BB;
        step();
        step();
        chk("ts_count", 200, 32'(count),     32'd2);
        chk("ts_data0", 200, 32'(host_data), 32'h00AA);
        chk("ts_stamp0", 200, 32'(host_ts),  32'd10);
        host_ready = 1'b1;
        step();
        host_ready = 1'b0;
        chk("ts_data1", 201, 32'(host_data), 32'h00BB);
        chk("ts_stamp1", 201, 32'(host_ts),  32'd20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
